netbus_fifo_ctrl: RTL and testbench

NETBUS_FIFO_CTRL -- requirements
Module: netbus_fifo_ctrl

---
 rtl/netbus_fifo_pkg.sv | 13 +
 rtl/netbus_fifo_outbuf.sv | 66 ++++++
 rtl/netbus_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_netbus_fifo_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/netbus_fifo_pkg.sv
// rtl/netbus_fifo_pkg.sv - shared constants and helpers for the netbus FIFO controller
package netbus_fifo_pkg;

    // Output queue depth: one registered read in flight plus enough slack to
    // keep a read issued every cycle while the consumer is stalled briefly.
    localparam int OB_DEPTH = 3;

    // Pointer width: one extra bit over the address so full and empty differ.
    function automatic int ptr_width(input int ram_depth);
        return ram_depth + 1;
    endfunction

endpackage

// File: rtl/netbus_fifo_outbuf.sv
// rtl/netbus_fifo_outbuf.sv - 3-entry output queue holding words returned by the memory
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (clears indices and count)
//   push       write push_data into the queue
//   push_data  word to store
//   pop        remove the head word (ignored when empty)
//   head       oldest stored word
//   count      number of stored words, 0..3
module netbus_fifo_outbuf
    import netbus_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot [OB_DEPTH];
    logic [1:0]       rd_idx;
    logic [1:0]       wr_idx;
    logic             do_push;
    logic             do_pop;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'(OB_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push && ((count != 2'(OB_DEPTH)) || do_pop);
    assign head    = slot[rd_idx];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slot[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx <= 2'd0;
            wr_idx <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (do_pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/netbus_fifo_ctrl.sv
// rtl/netbus_fifo_ctrl.sv - FIFO controller around an external 1-cycle-latency RAM
//
// Optional feature macro: NETBUS_FIFO_LEVEL_EN adds the LEVEL occupancy output.
//
// Ports:
//   CLK        clock (also drives both RAM ports outside this block)
//   RST        synchronous active-high reset
//   WR_VALID / WR_READY / WR_DATA   producer handshake
//   RD_VALID / RD_READY / RD_DATA   consumer handshake, RD_DATA is the oldest word
//   MEM_WADDR / MEM_DIN / MEM_WEN   RAM write port
//   MEM_RADDR / MEM_DOUT            RAM read port, registered data, no read enable
//   LEVEL      (NETBUS_FIFO_LEVEL_EN only) words written minus words read
module netbus_fifo_ctrl
    import netbus_fifo_pkg::*;
#(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    input  logic [RAM_WIDTH-1:0] WR_DATA,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    output logic [RAM_WIDTH-1:0] RD_DATA,
    output logic [RAM_DEPTH-1:0] MEM_WADDR,
    output logic [RAM_WIDTH-1:0] MEM_DIN,
    output logic                 MEM_WEN,
    output logic [RAM_DEPTH-1:0] MEM_RADDR,
    input  logic [RAM_WIDTH-1:0] MEM_DOUT
`ifdef NETBUS_FIFO_LEVEL_EN
    ,
    output logic [RAM_DEPTH+1:0] LEVEL
`endif
);

    localparam int PW = ptr_width(RAM_DEPTH);

    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [PW-1:0]        ram_cnt;
    logic                 ram_full;
    logic                 ram_empty;
    logic                 inflight;
    logic                 wr_hs;
    logic                 rd_issue;
    logic                 rd_hs;
    logic [1:0]           ob_cnt;
    logic [RAM_WIDTH-1:0] ob_head;

    assign ram_cnt   = wptr - rptr;
    assign ram_full  = (ram_cnt == {1'b1, {RAM_DEPTH{1'b0}}});
    assign ram_empty = (ram_cnt == '0);

    // Depends only on registered pointers, so RD_READY never reaches WR_READY.
    assign WR_READY  = !ram_full && !RST;
    assign wr_hs     = WR_VALID && WR_READY;

    assign MEM_WEN   = wr_hs;
    assign MEM_WADDR = wptr[RAM_DEPTH-1:0];
    assign MEM_DIN   = WR_DATA;
    assign MEM_RADDR = rptr[RAM_DEPTH-1:0];

    // Only issue a RAM read when the output queue is guaranteed a free slot
    // for it, counting the read that is already on its way back.
    assign rd_issue  = !ram_empty && (({1'b0, ob_cnt} + {2'b00, inflight}) < 3'(OB_DEPTH));

    assign RD_VALID  = (ob_cnt != 2'd0) && !RST;
    assign RD_DATA   = ob_head;
    assign rd_hs     = RD_VALID && RD_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
        end else begin
            if (wr_hs) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_issue) begin
                rptr <= rptr + 1'b1;
            end
            inflight <= rd_issue;
        end
    end

    // MEM_DOUT is valid exactly one cycle after the issue, i.e. while inflight.
    netbus_fifo_outbuf #(
        .WIDTH (RAM_WIDTH)
    ) u_outbuf (
        .clk       (CLK),
        .rst       (RST),
        .push      (inflight),
        .push_data (MEM_DOUT),
        .pop       (rd_hs),
        .head      (ob_head),
        .count     (ob_cnt)
    );

`ifdef NETBUS_FIFO_LEVEL_EN
    localparam int LW = RAM_DEPTH + 2;

    logic [LW-1:0] level_q;

    // Tracked from the handshakes, which equals ram_cnt + inflight + ob_cnt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q <= '0;
        end else if (wr_hs && !rd_hs) begin
            level_q <= level_q + 1'b1;
        end else if (!wr_hs && rd_hs) begin
            level_q <= level_q - 1'b1;
        end
    end

    assign LEVEL = level_q;
`endif

endmodule

// File: tb/tb_netbus_fifo_ctrl.sv
// tb/tb_netbus_fifo_ctrl.sv - scoreboard bench for netbus_fifo_ctrl with a behavioural RAM
module tb_netbus_fifo_ctrl;

    localparam int W        = 16;
    localparam int D        = 4;
    localparam int RAM_SIZE = 1 << D;
    localparam int CAPACITY = RAM_SIZE + 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         WR_VALID = 1'b0;
    logic         WR_READY;
    logic [W-1:0] WR_DATA = '0;
    logic         RD_VALID;
    logic         RD_READY = 1'b0;
    logic [W-1:0] RD_DATA;
    logic [D-1:0] MEM_WADDR;
    logic [W-1:0] MEM_DIN;
    logic         MEM_WEN;
    logic [D-1:0] MEM_RADDR;
    logic [W-1:0] MEM_DOUT = '0;
`ifdef NETBUS_FIFO_LEVEL_EN
    logic [D+1:0] LEVEL;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    int           lvl_model = 0;
    logic         post_rst  = 1'b0;

    always #5 CLK = ~CLK;

    netbus_fifo_ctrl #(
        .RAM_WIDTH (W),
        .RAM_DEPTH (D)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_VALID  (WR_VALID),
        .WR_READY  (WR_READY),
        .WR_DATA   (WR_DATA),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .RD_DATA   (RD_DATA),
        .MEM_WADDR (MEM_WADDR),
        .MEM_DIN   (MEM_DIN),
        .MEM_WEN   (MEM_WEN),
        .MEM_RADDR (MEM_RADDR),
        .MEM_DOUT  (MEM_DOUT)
`ifdef NETBUS_FIFO_LEVEL_EN
        ,
        .LEVEL     (LEVEL)
`endif
    );

    // External RAM: synchronous write, registered read with no enable.
    logic [W-1:0] mem [RAM_SIZE];
    always @(posedge CLK) begin
        if (MEM_WEN) mem[MEM_WADDR] <= MEM_DIN;
        MEM_DOUT <= mem[MEM_RADDR];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: inputs change at the falling edge, the handshake
    // they produce happens at the next rising edge.
    task automatic cyc(input logic wv, input logic [W-1:0] wd, input logic rr,
                       input logic rst, output logic acc);
        @(negedge CLK);
        RST      = rst;
        WR_VALID = wv;
        WR_DATA  = wd;
        RD_READY = rr;
        #1;
        acc = wv && WR_READY && !rst;
        if (rst) exp_q.delete();
        else if (acc) exp_q.push_back(wd);
    endtask

    task automatic drain(input string name);
        logic acc;
        int   n = 0;
        while ((exp_q.size() != 0 || RD_VALID) && n < 300) begin
            cyc(1'b0, '0, 1'b1, 1'b0, acc);
            n++;
        end
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every read handshake and checks the
    // occupancy-derived rules against a simple word count.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                chk("rst_wr_ready", 32'(WR_READY), 32'd0);
                chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
                chk("rst_mem_wen", 32'(MEM_WEN), 32'd0);
                lvl_model = 0;
                post_rst  = 1'b1;
            end else begin
                if (post_rst) chk("post_rst_rd_valid", 32'(RD_VALID), 32'd0);
                post_rst = 1'b0;
`ifdef NETBUS_FIFO_LEVEL_EN
                chk("level", 32'(LEVEL), 32'(lvl_model));
`endif
                if (lvl_model < RAM_SIZE) chk("wr_ready_room", 32'(WR_READY), 32'd1);
                if (lvl_model == CAPACITY) chk("wr_ready_full", 32'(WR_READY), 32'd0);
                if (RD_VALID && RD_READY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_read", 32'(RD_DATA), 32'hFFFF_FFFF);
                    end else begin
                        chk("rd_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
                    end
                end
                lvl_model += ((WR_VALID && WR_READY) ? 1 : 0) - ((RD_VALID && RD_READY) ? 1 : 0);
            end
        end
    end

    initial begin
        logic acc;
        int   acc_cnt;
        int   first_valid;
        int   gaps;
        int   n;

        for (int i = 0; i < RAM_SIZE; i++) mem[i] = '0;

        cyc(1'b0, '0, 1'b0, 1'b1, acc);
        cyc(1'b1, 16'h5555, 1'b1, 1'b1, acc);
        chk("rst_no_accept", 32'(acc), 32'd0);

        // Single word latency; the write sits in the first cycle after reset.
        cyc(1'b1, 16'hA5A5, 1'b0, 1'b0, acc);
        chk("first_cycle_accept", 32'(acc), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        chk("lat_c1_valid", 32'(RD_VALID), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        chk("lat_c2_valid", 32'(RD_VALID), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        chk("lat_c3_valid", 32'(RD_VALID), 32'd1);
        chk("lat_c3_data", 32'(RD_DATA), 32'h0000_A5A5);
        drain("latency");

        // Fill to capacity with the consumer stalled.
        acc_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 16'(acc_cnt), 1'b0, 1'b0, acc);
            if (acc) acc_cnt++;
        end
        chk("capacity", 32'(acc_cnt), 32'(CAPACITY));
        chk("full_wr_ready", 32'(WR_READY), 32'd0);
        drain("full");

        // Streaming: one word per cycle after the fill latency, no gaps.
        first_valid = -1;
        gaps        = 0;
        acc_cnt     = 0;
        for (int i = 0; i < 110; i++) begin
            cyc(i < 100, 16'(16'h0100 + i), 1'b1, 1'b0, acc);
            if (acc) acc_cnt++;
            if (RD_VALID && first_valid < 0) first_valid = i;
            if (first_valid >= 0 && i < first_valid + 100 && !RD_VALID) gaps++;
        end
        chk("stream_accepted", 32'(acc_cnt), 32'd100);
        chk("stream_first_valid", 32'(first_valid), 32'd3);
        chk("stream_gaps", 32'(gaps), 32'd0);
        drain("stream");

        // Reset while holding ten words.
        acc_cnt = 0;
        n       = 0;
        while (acc_cnt < 10 && n < 50) begin
            cyc(1'b1, 16'(16'h0200 + acc_cnt), 1'b0, 1'b0, acc);
            if (acc) acc_cnt++;
            n++;
        end
        chk("pre_rst_words", 32'(acc_cnt), 32'd10);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0, acc);
        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, acc);
        chk("after_rst_rd_valid", 32'(RD_VALID), 32'd0);
`ifdef NETBUS_FIFO_LEVEL_EN
        chk("after_rst_level", 32'(LEVEL), 32'd0);
`endif
        chk("after_rst_accept", 32'(acc), 32'd1);
        drain("reset");

        // Random valid/ready traffic across many pointer wraps.
        acc_cnt = 0;
        n       = 0;
        while (acc_cnt < 10000 && n < 60000) begin
            cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, 1'b0, acc);
            if (acc) acc_cnt++;
            n++;
        end
        chk("random_words", 32'(acc_cnt), 32'd10000);
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
